// File: rtl/led_cnt_div.sv
// led_cnt_div: heartbeat LED counter advanced every 2^(div_reg+1) clocks by a 32-bit prescaler.
// Optional macro LED_WALK_EN replaces the binary count with a one-hot walking pattern.
module led_cnt_div #(
    parameter int LED_W   = 4,
    parameter int DIV_RST = 24
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       div_i,
    input  logic             wren_i,
    output logic [LED_W-1:0] led_o
);

`ifdef LED_WALK_EN
    localparam logic [LED_W-1:0] LED_RST = LED_W'(1);
`else
    localparam logic [LED_W-1:0] LED_RST = '0;
`endif

    logic [4:0]       div_reg;
    logic [31:0]      presc;
    logic [31:0]      tick_mask;
    logic             tick;
    logic [LED_W-1:0] led_cnt;
    logic [LED_W-1:0] led_next;

    // Low div_reg+1 bits set; div_reg=31 shifts the zero out and gives an all-ones mask.
    assign tick_mask = ~(32'hFFFF_FFFE << div_reg);
    assign tick      = ((presc & tick_mask) == tick_mask);

    // NOTE: combinational blocks assign every output first so no latch is inferred.
    always_comb begin
        led_next = led_cnt;
`ifdef LED_WALK_EN
        led_next = (led_cnt << 1) | (led_cnt >> (LED_W - 1));
`else
        led_next = led_cnt + LED_W'(1);
`endif
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_reg <= 5'(DIV_RST);
            presc   <= '0;
            led_cnt <= LED_RST;
        end else if (wren_i) begin
            // A write restarts the prescaler and swallows any tick landing on the same edge.
            div_reg <= div_i;
            presc   <= '0;
        end else begin
            presc <= presc + 32'd1;
            if (tick) begin
                led_cnt <= led_next;
            end
        end
    end

    assign led_o = led_cnt;

endmodule

// File: tb/tb_led_cnt_div.sv
// Bench for led_cnt_div: randomized stimulus checked against a step-count reference model.
// The model counts cycles since the last write/reset; it also covers the LED_WALK_EN build.
module tb_led_cnt_div;
    localparam int LED_W   = 4;
    localparam int DIV_RST = 2;

    logic             clk    = 1'b0;
    logic             rstn   = 1'b0;
    logic [4:0]       div_i  = '0;
    logic             wren_i = 1'b0;
    logic [LED_W-1:0] led_o;

    int checks   = 0;
    int failures = 0;

    led_cnt_div #(.LED_W(LED_W), .DIV_RST(DIV_RST)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .div_i  (div_i),
        .wren_i (wren_i),
        .led_o  (led_o)
    );

    always #5 clk = ~clk;

    // Reference model: number of LED steps taken so far, and cycles elapsed since the anchor.
    int unsigned model_steps = 0;
    longint      model_since = 0;
    int          model_div   = DIV_RST;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            model_steps = 0;
            model_since = 0;
            model_div   = DIV_RST;
        end else if (wren_i) begin
            model_div   = int'(div_i);
            model_since = 0;
        end else begin
            model_since = model_since + 1;
            if (model_since % (longint'(1) << (model_div + 1)) == 0)
                model_steps = model_steps + 1;
        end
    end

    function automatic logic [LED_W-1:0] led_of(input int unsigned steps);
        logic [LED_W-1:0] one;
        one = LED_W'(1);
`ifdef LED_WALK_EN
        return one << (steps % LED_W);
`else
        return LED_W'(steps);
`endif
    endfunction

    task automatic test_reset();
        int k;
        logic [LED_W-1:0] prev;
        rstn = 1'b0; wren_i = 1'b0;
        #20;
        checks++;
        if (led_o !== led_of(0)) begin
            failures++;
            $display("FAIL reset_value got=%h exp=%h", led_o, led_of(0));
        end
        @(negedge clk);
        checks++;
        if (led_o !== led_of(0)) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=%h", led_o, led_of(0));
        end
        rstn = 1'b1;
        @(negedge clk);
        wren_i = 1'b1; div_i = 5'd1;
        @(negedge clk);
        wren_i = 1'b0;
        prev = led_o;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (led_o !== prev) break;
        end
        checks++;
        if (k != 4 || led_o !== led_of(1)) begin
            failures++;
            $display("FAIL first_step_after_write got_cycle=%0d got=%h exp_cycle=4 exp=%h", k, led_o, led_of(1));
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (led_o !== led_of(model_steps)) begin
                failures++;
                $display("FAIL div1_rate got=%h exp=%h", led_o, led_of(model_steps));
            end
        end
    endtask

    task automatic test_default_rate();
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 1; i <= 136; i++) begin
            @(negedge clk);
            checks++;
            if (led_o !== led_of(model_steps)) begin
                failures++;
                $display("FAIL default_rate cyc=%0d got=%h exp=%h", i, led_o, led_of(model_steps));
            end
            if (i == 127) begin
                checks++;
                if (led_o !== led_of(15)) begin
                    failures++;
                    $display("FAIL before_wrap got=%h exp=%h", led_o, led_of(15));
                end
            end
            if (i == 128) begin
                checks++;
                if (led_o !== led_of(0)) begin
                    failures++;
                    $display("FAIL wrap_to_zero got=%h exp=%h", led_o, led_of(0));
                end
            end
        end
    endtask

    task automatic test_collision();
        int unsigned s0;
        int k;
        @(negedge clk);
        wren_i = 1'b1; div_i = 5'd1;
        @(negedge clk);
        wren_i = 1'b0;
        for (k = 0; k < 10; k++) begin
            if (model_since % 4 == 3) break;
            @(negedge clk);
        end
        checks++;
        if (k == 10) begin
            failures++;
            $display("FAIL collision_align got=timeout exp=aligned");
        end
        s0 = model_steps;
        wren_i = 1'b1; div_i = 5'd0;
        @(negedge clk);
        wren_i = 1'b0;
        checks++;
        if (led_o !== led_of(s0)) begin
            failures++;
            $display("FAIL collision_suppressed got=%h exp=%h", led_o, led_of(s0));
        end
        @(negedge clk);
        checks++;
        if (led_o !== led_of(s0)) begin
            failures++;
            $display("FAIL collision_hold1 got=%h exp=%h", led_o, led_of(s0));
        end
        @(negedge clk);
        checks++;
        if (led_o !== led_of(s0 + 1)) begin
            failures++;
            $display("FAIL collision_first_step got=%h exp=%h", led_o, led_of(s0 + 1));
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (led_o !== led_of(model_steps)) begin
                failures++;
                $display("FAIL div0_rate got=%h exp=%h", led_o, led_of(model_steps));
            end
        end
    endtask

    task automatic test_hold();
        int d;
        int k;
        int period;
        int unsigned s0;
        logic [LED_W-1:0] held;
        d = int'($urandom_range(0, 3));
        period = 1 << (d + 1);
        s0 = model_steps;
        held = led_of(s0);
        wren_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            div_i = (i == 49) ? 5'(d) : 5'($urandom_range(0, 31));
            @(negedge clk);
            checks++;
            if (led_o !== held) begin
                failures++;
                $display("FAIL hold_frozen cyc=%0d got=%h exp=%h", i, led_o, held);
            end
        end
        wren_i = 1'b0;
        div_i = 5'($urandom_range(0, 31));
        for (k = 1; k <= period + 4; k++) begin
            @(negedge clk);
            if (led_o !== held) break;
        end
        checks++;
        if (k != period || led_o !== led_of(s0 + 1)) begin
            failures++;
            $display("FAIL hold_release got_cycle=%0d got=%h exp_cycle=%0d exp=%h", k, led_o, period, led_of(s0 + 1));
        end
    endtask

    task automatic test_async_reset();
        int k;
        wren_i = 1'b1; div_i = 5'd0;
        @(negedge clk);
        wren_i = 1'b0;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (led_o === led_of(5)) break;
        end
        checks++;
        if (k == 40) begin
            failures++;
            $display("FAIL reach_five got=%h exp=%h", led_o, led_of(5));
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (led_o !== led_of(0)) begin
            failures++;
            $display("FAIL async_reset_immediate got=%h exp=%h", led_o, led_of(0));
        end
        @(negedge clk);
        checks++;
        if (led_o !== led_of(0)) begin
            failures++;
            $display("FAIL async_reset_hold got=%h exp=%h", led_o, led_of(0));
        end
        rstn = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks++;
            if (led_o !== led_of(model_steps)) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, led_o, led_of(model_steps));
            end
            div_i = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) begin
                wren_i = 1'b1;
                div_i  = 5'($urandom_range(0, 4));
            end else begin
                wren_i = 1'b0;
            end
        end
        wren_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_rate();
        test_collision();
        test_hold();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
